// File: rtl/reg_file_gen_if.sv
// rtl/reg_file_gen_if.sv - write/read/return-stack bundle between pipeline stages and reg_file_gen
interface reg_file_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
);
  localparam int LANES = DATA_W / 8;

  logic                     stall;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [LANES-1:0]         wr_be;
  logic [DATA_W-1:0]        wr_data;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic                     ras_push;
  logic [2*DATA_W-1:0]      ras_push_addr;
  logic                     ras_pop;
  logic                     ras_clr_flags;
  logic [2*DATA_W-1:0]      ras_top;
  logic                     ras_empty;
  logic                     ras_full;
  logic                     ras_overflow;
  logic                     ras_underflow;

  modport master (
    output stall, wr_en, wr_addr, wr_be, wr_data, rd_addr,
           ras_push, ras_push_addr, ras_pop, ras_clr_flags,
    input  rd_data, ras_top, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, wr_en, wr_addr, wr_be, wr_data, rd_addr,
           ras_push, ras_push_addr, ras_pop, ras_clr_flags,
    output rd_data, ras_top, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/reg_file_gen.sv
// rtl/reg_file_gen.sv - byte-lane register file with forwarding read ports and circular return-address stack
module reg_file_gen #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int N_RD      = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_file_gen_if.slave  bus
);
  localparam int LANES = DATA_W / 8;
  localparam int NREG  = 2 ** ADDR_W;
  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = SP_W + 1;

  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] STAT_A  = ADDR_W'(NREG - 2);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [DATA_W-1:0]   regs_q     [NREG];
  logic [ADDR_W-1:0]   cap_addr_q [N_RD];
  logic [DATA_W-1:0]   cap_data_q [N_RD];
  logic                pw_en_q;
  logic [ADDR_W-1:0]   pw_addr_q;
  logic [LANES-1:0]    pw_be_q;
  logic [DATA_W-1:0]   pw_data_q;

  logic [2*DATA_W-1:0] ras_q [RAS_DEPTH];
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                ras_we;
  logic [SP_W-1:0]     ras_wptr;

  logic                wr_live;
  logic                wr_commit;
  logic                ras_empty_w;
  logic                ras_full_w;
  logic [DATA_W-1:0]   stat_w;
  logic [ADDR_W-1:0]   rd_addr_a [N_RD];
  logic [DATA_W-1:0]   rd_val    [N_RD];
  logic [N_RD*DATA_W-1:0] rd_data_c;

  assign wr_live     = bus.wr_en & ~bus.stall;
  assign wr_commit   = wr_live & (bus.wr_addr != ZERO_A) & (bus.wr_addr != STAT_A);
  assign ras_empty_w = (cnt_q == '0);
  assign ras_full_w  = (cnt_q == DEPTH_C);
  assign stat_w      = {{(DATA_W-4){1'b0}}, unf_q, ovf_q, ras_full_w, ras_empty_w};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      for (int l = 0; l < LANES; l++)
        if (bus.wr_be[l]) regs_q[bus.wr_addr][8*l +: 8] <= bus.wr_data[8*l +: 8];
    end
  end

  always_comb begin
    for (int p = 0; p < N_RD; p++) begin
      rd_addr_a[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
      rd_val[p]    = regs_q[rd_addr_a[p]];
      if (rd_addr_a[p] == ZERO_A)      rd_val[p] = '0;
      else if (rd_addr_a[p] == STAT_A) rd_val[p] = stat_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_RD; p++) begin
        cap_addr_q[p] <= '0;
        cap_data_q[p] <= '0;
      end
    end else if (!bus.stall) begin
      for (int p = 0; p < N_RD; p++) begin
        cap_addr_q[p] <= rd_addr_a[p];
        cap_data_q[p] <= rd_val[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_en_q   <= 1'b0;
      pw_addr_q <= '0;
      pw_be_q   <= '0;
      pw_data_q <= '0;
    end else begin
      pw_en_q   <= wr_live;
      pw_addr_q <= bus.wr_addr;
      pw_be_q   <= bus.wr_be;
      pw_data_q <= bus.wr_data;
    end
  end

  // Captured value predates the write committed at the same edge, so the
  // previous write has to be replayed on top of it alongside the live one.
  always_comb begin
    rd_data_c = '0;
    for (int p = 0; p < N_RD; p++) begin
      for (int l = 0; l < LANES; l++) begin
        rd_data_c[p*DATA_W + 8*l +: 8] = cap_data_q[p][8*l +: 8];
        if (cap_addr_q[p] != ZERO_A && cap_addr_q[p] != STAT_A) begin
          if (wr_live && bus.wr_be[l] && bus.wr_addr == cap_addr_q[p])
            rd_data_c[p*DATA_W + 8*l +: 8] = bus.wr_data[8*l +: 8];
          else if (pw_en_q && pw_be_q[l] && pw_addr_q == cap_addr_q[p])
            rd_data_c[p*DATA_W + 8*l +: 8] = pw_data_q[8*l +: 8];
        end
      end
    end
  end

  // Live-write forwarding must not leak through while reset is held.
  assign bus.rd_data = rst_n ? rd_data_c : '0;

  always_comb begin
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_we   = 1'b0;
    ras_wptr = sp_q;
    if (!bus.stall) begin
      if (bus.ras_push && (!bus.ras_pop || ras_empty_w)) begin
        ras_we   = 1'b1;
        ras_wptr = sp_q;
        sp_d     = sp_q + 1'b1;
        if (!ras_full_w) cnt_d = cnt_q + 1'b1;
      end else if (bus.ras_push && bus.ras_pop) begin
        ras_we   = 1'b1;
        ras_wptr = sp_q - 1'b1;
      end else if (bus.ras_pop && !ras_empty_w) begin
        sp_d  = sp_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
      if (bus.ras_clr_flags) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (bus.ras_push && !bus.ras_pop && ras_full_w) ovf_d = 1'b1;
      if (bus.ras_pop && !bus.ras_push && ras_empty_w) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ras_we) ras_q[ras_wptr] <= bus.ras_push_addr;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.ras_top       = ras_empty_w ? '0 : ras_q[sp_q - 1'b1];
  assign bus.ras_empty     = ras_empty_w;
  assign bus.ras_full      = ras_full_w;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_reg_file_gen.sv
// tb/tb_reg_file_gen.sv - directed self-checking bench for reg_file_gen
module tb_reg_file_gen;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  reg_file_gen_if #(.DATA_W(16), .ADDR_W(5), .N_RD(2)) bus ();

  reg_file_gen #(.DATA_W(16), .ADDR_W(5), .N_RD(2), .RAS_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [1:0] be, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_be   = be;
    bus.wr_data = d;
  endtask

  function automatic logic [31:0] rd0();
    return {16'h0, bus.rd_data[15:0]};
  endfunction

  function automatic logic [31:0] rd1();
    return {16'h0, bus.rd_data[31:16]};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_be = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    bus.ras_push = 1'b0;
    bus.ras_push_addr = '0;
    bus.ras_pop = 1'b0;
    bus.ras_clr_flags = 1'b0;
    #1;
    chk("reset_rd0", rd0(), 32'h0);
    chk("reset_empty", {31'h0, bus.ras_empty}, 32'h1);
    chk("reset_full", {31'h0, bus.ras_full}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Populate r1 and the RAS, then reset mid-write
    wr(5'd1, 2'b11, 16'h1111);
    bus.ras_push = 1'b1;
    bus.ras_push_addr = 32'h0000_0100;
    set_rd(5'd0, 5'd1);
    tick();
    bus.wr_en = 1'b0;
    bus.ras_push = 1'b0;
    tick();
    chk("r1_read", rd1(), 32'h1111);
    chk("ras_top_one", bus.ras_top, 32'h0000_0100);
    chk("ras_nonempty", {31'h0, bus.ras_empty}, 32'h0);
    wr(5'd1, 2'b11, 16'h2222);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rd1", rd1(), 32'h0);
    chk("async_empty", {31'h0, bus.ras_empty}, 32'h1);
    chk("async_top", bus.ras_top, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.wr_en = 1'b0;
    tick();
    chk("post_reset_r1", rd1(), 32'h0);

    // Lane write
    wr(5'd3, 2'b11, 16'h0000);
    tick();
    wr(5'd3, 2'b10, 16'hABCD);
    tick();
    bus.wr_en = 1'b0;
    set_rd(5'd3, 5'd0);
    tick();
    chk("lane_write", rd0(), 32'hAB00);
    wr(5'd3, 2'b00, 16'hFFFF);
    #1;
    chk("be0_live", rd0(), 32'hAB00);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("be0_prev", rd0(), 32'hAB00);
    tick();
    chk("be0_array", rd0(), 32'hAB00);

    // Forwarding
    set_rd(5'd5, 5'd5);
    wr(5'd5, 2'b11, 16'h1234);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("fwd1_p0", rd0(), 32'h1234);
    chk("fwd1_p1", rd1(), 32'h1234);
    wr(5'd5, 2'b11, 16'h5678);
    #1;
    chk("fwd0_wins", rd0(), 32'h5678);
    tick();
    wr(5'd5, 2'b01, 16'h9A9A);
    #1;
    chk("fwd_lane_mix", rd0(), 32'h569A);
    tick();
    bus.wr_en = 1'b0;
    tick();
    chk("fwd_settled", rd0(), 32'h569A);

    // Stall
    set_rd(5'd2, 5'd5);
    tick();
    chk("stall_pre", rd0(), 32'h0);
    bus.stall = 1'b1;
    wr(5'd2, 2'b11, 16'hFFFF);
    set_rd(5'd2, 5'd3);
    #1;
    chk("stall_no_fwd", rd0(), 32'h0);
    chk("stall_hold_p1", rd1(), 32'h569A);
    tick();
    chk("stall_r2", rd0(), 32'h0);
    chk("stall_hold_p1b", rd1(), 32'h569A);
    bus.stall = 1'b0;
    #1;
    chk("unstall_fwd0", rd0(), 32'hFFFF);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("unstall_commit", rd0(), 32'hFFFF);
    chk("unstall_p1", rd1(), 32'hAB00);

    // ZERO address
    set_rd(5'd31, 5'd3);
    tick();
    chk("zero_read", rd0(), 32'h0);
    wr(5'd31, 2'b11, 16'h5555);
    #1;
    chk("zero_no_fwd0", rd0(), 32'h0);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("zero_no_fwd1", rd0(), 32'h0);
    tick();
    chk("zero_dropped", rd0(), 32'h0);

    // STAT address and underflow
    set_rd(5'd30, 5'd3);
    tick();
    chk("stat_empty", rd0(), 32'h0001);
    bus.ras_pop = 1'b1;
    tick();
    bus.ras_pop = 1'b0;
    #1;
    chk("underflow_set", {31'h0, bus.ras_underflow}, 32'h1);
    tick();
    chk("stat_unf", rd0(), 32'h0009);
    wr(5'd30, 2'b11, 16'hFFFF);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("stat_no_fwd", rd0(), 32'h0009);
    tick();
    chk("stat_dropped", rd0(), 32'h0009);
    bus.ras_clr_flags = 1'b1;
    tick();
    bus.ras_clr_flags = 1'b0;
    tick();
    chk("stat_cleared", rd0(), 32'h0001);

    // RAS overflow
    for (int i = 1; i <= 9; i++) begin
      bus.ras_push = 1'b1;
      bus.ras_push_addr = 32'(i);
      tick();
    end
    bus.ras_push = 1'b0;
    #1;
    chk("ras_full", {31'h0, bus.ras_full}, 32'h1);
    chk("ras_overflow", {31'h0, bus.ras_overflow}, 32'h1);
    chk("ras_top9", bus.ras_top, 32'h9);
    tick();
    chk("stat_full_ovf", rd0(), 32'h0006);
    for (int k = 1; k <= 8; k++) begin
      bus.ras_pop = 1'b1;
      tick();
      chk($sformatf("pop_%0d_top", k), bus.ras_top, (k < 8) ? 32'(9 - k) : 32'h0);
    end
    bus.ras_pop = 1'b0;
    #1;
    chk("pop_empty", {31'h0, bus.ras_empty}, 32'h1);
    chk("pop_not_full", {31'h0, bus.ras_full}, 32'h0);
    chk("pop_no_unf", {31'h0, bus.ras_underflow}, 32'h0);

    // Push & pop together
    bus.ras_push = 1'b1;
    bus.ras_pop = 1'b1;
    bus.ras_push_addr = 32'hDEAD_BEEF;
    tick();
    bus.ras_push = 1'b0;
    bus.ras_pop = 1'b0;
    #1;
    chk("pp_empty_top", bus.ras_top, 32'hDEAD_BEEF);
    chk("pp_empty_unf", {31'h0, bus.ras_underflow}, 32'h0);
    bus.ras_pop = 1'b1;
    tick();
    bus.ras_pop = 1'b0;
    #1;
    chk("pp_count1", {31'h0, bus.ras_empty}, 32'h1);
    bus.ras_push = 1'b1;
    bus.ras_push_addr = 32'h11;
    tick();
    bus.ras_pop = 1'b1;
    bus.ras_push_addr = 32'h22;
    tick();
    bus.ras_push = 1'b0;
    bus.ras_pop = 1'b0;
    #1;
    chk("pp_replace_top", bus.ras_top, 32'h22);
    bus.ras_pop = 1'b1;
    tick();
    bus.ras_pop = 1'b0;
    #1;
    chk("pp_replace_count", {31'h0, bus.ras_empty}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
